// File: rtl/chan_collect.sv
// Purpose : pipeline-end collector; keeps the newest word per output channel and
//           re-serializes pending words round-robin toward the output stage.
// Latency : 2 cycles from dv_in to out_dv when idle; one word per cycle sustained.
// Backpr. : out_rdy low holds the presented word stable; the input side has no
//           backpressure, so repeated writes to a pending channel coalesce and
//           raise that channel's sticky overrun flag.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   dv_in, chan_in, data_in   input word (one-cycle pulse, never stalled)
//   out_rdy                   downstream ready
//   ovr_clr                   clears all overrun flags
//   out_dv, out_chan, out_data presented output word (registered)
//   ovr_out                   sticky per-channel overrun flags
module chan_collect #(
    parameter int N_CHAN = 8,
    parameter int W_CHAN = 5,
    parameter int W_DATA = 18
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              dv_in,
    input  logic [W_CHAN-1:0] chan_in,
    input  logic [W_DATA-1:0] data_in,
    input  logic              out_rdy,
    input  logic              ovr_clr,
    output logic              out_dv,
    output logic [W_CHAN-1:0] out_chan,
    output logic [W_DATA-1:0] out_data,
    output logic [N_CHAN-1:0] ovr_out
);

    logic [W_DATA-1:0] data_mem [N_CHAN];
    logic [N_CHAN-1:0] pend;
    logic [N_CHAN-1:0] wr;
    logic [N_CHAN-1:0] grant;
    logic [W_CHAN-1:0] rr_ptr;
    logic [W_CHAN-1:0] grant_idx;
    logic [W_DATA-1:0] grant_data;
    logic              grant_any;
    logic              load_ok;
    logic              xfer;

    // The output register may reload when empty or when its word leaves this cycle.
    assign xfer    = out_dv & out_rdy;
    assign load_ok = ~out_dv | out_rdy;

    // One-hot write decode; indices >= N_CHAN match no bit and are dropped.
    always_comb begin : write_decode
        wr = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            wr[c] = dv_in & (chan_in == W_CHAN'(c));
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin : arbiter
        int idx;
        idx        = 0;
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int k = 1; k <= N_CHAN; k++) begin
            idx = (int'(rr_ptr) + k) % N_CHAN;
            if (load_ok && !grant_any && pend[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = W_CHAN'(idx);
                grant_data = data_mem[idx];
            end
        end
    end

    // Holding registers need no reset: a word is only read while its pend bit is set.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (wr[c]) begin
                    data_mem[c] <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend     <= '0;
            ovr_out  <= '0;
            out_dv   <= 1'b0;
            out_chan <= '0;
            out_data <= '0;
            rr_ptr   <= W_CHAN'(N_CHAN - 1);
        end else begin
            // A write to the channel granted this cycle re-arms it rather than
            // overrunning: the grant carries away the old word.
            pend <= (pend & ~grant) | wr;

            // Overrun is OR-ed after the clear so a same-cycle event survives it.
            ovr_out <= (ovr_clr ? '0 : ovr_out) | (wr & pend & ~grant);

            if (grant_any) begin
                out_dv   <= 1'b1;
                out_chan <= grant_idx;
                out_data <= grant_data;
                rr_ptr   <= grant_idx;
            end else if (xfer) begin
                out_dv   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_chan_collect.sv
// Purpose : self-checking bench for chan_collect; a behavioural model predicts every
//           presented word into a scoreboard queue, a negedge monitor pops on handshakes.
// Latency : model is cycle-level (words appear 2 cycles after input when idle).
// Backpr. : out_rdy is driven randomly and by directed scenarios.
module tb_chan_collect;

    localparam int N_CHAN = 8;
    localparam int W_CHAN = 5;
    localparam int W_DATA = 18;

    logic              clk;
    logic              rst;
    logic              dv;
    logic [W_CHAN-1:0] chan;
    logic [W_DATA-1:0] data;
    logic              rdy;
    logic              clr;
    logic              out_dv;
    logic [W_CHAN-1:0] out_chan;
    logic [W_DATA-1:0] out_data;
    logic [N_CHAN-1:0] ovr;

    chan_collect #(.N_CHAN(N_CHAN), .W_CHAN(W_CHAN), .W_DATA(W_DATA)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .dv_in    (dv),
        .chan_in  (chan),
        .data_in  (data),
        .out_rdy  (rdy),
        .ovr_clr  (clr),
        .out_dv   (out_dv),
        .out_chan (out_chan),
        .out_data (out_data),
        .ovr_out  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W_DATA-1:0]        m_val [N_CHAN];
    bit                       m_pend [N_CHAN];
    logic [N_CHAN-1:0]        m_ovr  = '0;
    logic                     m_dv   = 1'b0;
    logic [W_CHAN-1:0]        m_chan = '0;
    logic [W_DATA-1:0]        m_data = '0;
    int                       m_last = N_CHAN - 1;
    int                       m_g;
    int                       m_c;
    logic [W_CHAN+W_DATA-1:0] exp_q [$];
    logic [W_CHAN+W_DATA-1:0] got_q [$];
    logic [W_CHAN+W_DATA-1:0] want_q [$];

    initial begin
        for (int i = 0; i < N_CHAN; i++) m_pend[i] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CHAN; i++) m_pend[i] = 1'b0;
            m_ovr  = '0;
            m_dv   = 1'b0;
            m_chan = '0;
            m_data = '0;
            m_last = N_CHAN - 1;
            exp_q.delete();
        end else begin
            m_g = -1;
            if (!m_dv || rdy) begin
                for (int k = 1; k <= N_CHAN; k++) begin
                    m_c = (m_last + k) % N_CHAN;
                    if (m_g < 0 && m_pend[m_c]) m_g = m_c;
                end
            end
            if (clr) m_ovr = '0;
            if (dv && int'(chan) < N_CHAN && m_pend[chan] && m_g != int'(chan))
                m_ovr[chan] = 1'b1;
            if (m_g >= 0) begin
                m_dv   = 1'b1;
                m_chan = W_CHAN'(m_g);
                m_data = m_val[m_g];
                m_pend[m_g] = 1'b0;
                m_last = m_g;
                exp_q.push_back({m_chan, m_data});
            end else if (m_dv && rdy) begin
                m_dv = 1'b0;
            end
            if (dv && int'(chan) < N_CHAN) begin
                m_val[chan]  = data;
                m_pend[chan] = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [W_CHAN+W_DATA-1:0] e;
        forever begin
            @(negedge clk);
            chk("out_dv",   32'(out_dv),   32'(m_dv));
            chk("out_chan", 32'(out_chan), 32'(m_chan));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("ovr_out",  32'(ovr),      32'(m_ovr));
            if (out_dv && rdy && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_word", 32'({out_chan, out_data}), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_word", 32'({out_chan, out_data}), 32'(e));
                end
                got_q.push_back({out_chan, out_data});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        dv  = 1'b0;
        clr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int c, input int d);
        dv   = 1'b1;
        chan = W_CHAN'(c);
        data = W_DATA'(d);
        tick();
    endtask

    task automatic want(input int c, input int d);
        want_q.push_back({W_CHAN'(c), W_DATA'(d)});
    endtask

    task automatic chk_got(input string nm);
        chk($sformatf("%s_count", nm), 32'(got_q.size()), 32'(want_q.size()));
        for (int i = 0; i < want_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("%s_word%0d", nm, i), 32'(got_q[i]), 32'(want_q[i]));
        end
        got_q.delete();
        want_q.delete();
    endtask

    initial begin
        rst = 1'b1; dv = 1'b0; chan = '0; data = '0; rdy = 1'b0; clr = 1'b0;
        tick();
        tick();
        chk("rst_out_dv",   32'(out_dv),   32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ovr",      32'(ovr),      32'd0);

        // single word: visible exactly two edges after the input edge
        rdy = 1'b1;
        wr(3, 'h1ABCD);
        chk("single_lat1_dv", 32'(out_dv), 32'd0);
        tick();
        chk("single_dv",   32'(out_dv),   32'd1);
        chk("single_chan", 32'(out_chan), 32'd3);
        chk("single_data", 32'(out_data), 32'h1ABCD);
        chk("single_ovr",  32'(ovr),      32'd0);
        tick();
        chk("single_drop", 32'(out_dv), 32'd0);
        want(3, 'h1ABCD);
        chk_got("single");

        // round-robin: 7 occupies the output, then 5,1,6 pend; search resumes at 0
        rdy = 1'b0;
        wr(7, 'h7); wr(5, 'h5); wr(1, 'h1); wr(6, 'h6);
        rdy = 1'b1;
        ticks(6);
        want(7, 'h7); want(1, 'h1); want(5, 'h5); want(6, 'h6);
        chk_got("rr");
        // with 6 last granted, pending {0,6} wraps to 0 first
        rdy = 1'b0;
        wr(6, 'h66); wr(6, 'h67); wr(0, 'h10);
        rdy = 1'b1;
        ticks(5);
        want(6, 'h66); want(0, 'h10); want(6, 'h67);
        chk_got("rr_wrap");
        chk("rr_ovr", 32'(ovr), 32'd0);

        // backpressure + coalesce
        rdy = 1'b0;
        wr(2, 10); wr(2, 20); wr(2, 30);
        chk("coal_dv",   32'(out_dv),   32'd1);
        chk("coal_data", 32'(out_data), 32'd10);
        chk("coal_ovr",  32'(ovr),      32'h04);
        tick();
        chk("coal_hold", 32'(out_data), 32'd10);
        rdy = 1'b1;
        ticks(4);
        want(2, 10); want(2, 30);
        chk_got("coal");
        clr = 1'b1;
        tick();
        chk("coal_clr", 32'(ovr), 32'd0);

        // write to chan 4 at the edge it is granted
        rdy = 1'b0;
        wr(1, 'h111); wr(4, 'h444);
        rdy = 1'b1;
        wr(4, 'h555);
        ticks(3);
        want(1, 'h111); want(4, 'h444); want(4, 'h555);
        chk_got("same_cyc");
        chk("same_cyc_ovr", 32'(ovr), 32'd0);

        // overrun on chan 1 coincident with clear: flag survives
        rdy = 1'b0;
        wr(3, 'h333); wr(1, 'haaa);
        clr = 1'b1;
        wr(1, 'hbbb);
        chk("clr_vs_ovr", 32'(ovr), 32'h02);
        rdy = 1'b1;
        ticks(4);
        want(3, 'h333); want(1, 'hbbb);
        chk_got("clr_vs_ovr");
        clr = 1'b1;
        tick();
        chk("clr2", 32'(ovr), 32'd0);

        // out-of-range channels are dropped
        wr(8, 1); wr(31, 2);
        ticks(3);
        chk("oor_dv",  32'(out_dv), 32'd0);
        chk("oor_ovr", 32'(ovr),    32'd0);
        chk_got("oor");

        // reset while a word is presented and others pend; dv during reset ignored
        rdy = 1'b0;
        wr(1, 'h1001); wr(2, 'h2002); wr(3, 'h3003); wr(4, 'h4004);
        chk("pre_rst_dv", 32'(out_dv), 32'd1);
        rst = 1'b1; dv = 1'b1; chan = 5; data = 'h5005;
        tick();
        chk("mid_rst_dv",   32'(out_dv),   32'd0);
        chk("mid_rst_chan", 32'(out_chan), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_ovr",  32'(ovr),      32'd0);
        rdy = 1'b1;
        ticks(5);
        chk("post_rst_idle", 32'(out_dv), 32'd0);
        chk_got("post_rst");
        wr(6, 'h6006);
        ticks(2);
        want(6, 'h6006);
        chk_got("post_rst_new");

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            dv   = ($urandom % 2) == 0;
            chan = W_CHAN'($urandom_range(0, 9));
            data = W_DATA'($urandom);
            rdy  = ($urandom % 4) != 0;
            clr  = ($urandom % 50) == 0;
            rst  = ($urandom % 400) == 0;
            tick();
        end
        rdy = 1'b1;
        ticks(12);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle",     32'(out_dv),       32'd0);
        got_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
